riscv_fetch_unit: RTL and testbench

Instruction fetch stage sitting between the core's synchronous instruction memory (`instr_mem`, preloaded by hex image) and the decode stage. It generates sequential PCs, issues one word read per cycle, absorbs the one-cycle memory latency in a small prefetch FIFO, and hands {pc, instr} pairs to decode over a valid/ready handshake. It also accepts a redirect from execute (branch/jump) that flushes all speculative fetches.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/riscv_fetch_unit_sync_fifo.sv | 64 ++++++
 rtl/riscv_fetch_unit.sv | 117 +++++++++++
 tb/tb_riscv_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the instruction fetch path.
//   XLEN / ILEN  : PC and instruction widths
//   RESET_PC     : default first fetch address
//   NOP_INSTR    : canonical NOP encoding (addi x0, x0, 0)
//   fetch_entry_t: {pc, instr} pair handed from fetch to decode
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = ILEN / 8;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with push/pop/flush and occupancy output.
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : write i_wdata (ignored when full)
//   i_pop      : drop head entry (ignored when empty)
//   i_flush    : empty the FIFO (has priority over push/pop)
//   o_rdata    : head entry (combinational read of storage)
//   o_count    : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Guard against overflow/underflow so the pointers never desynchronise.
  assign w_do_push = i_push && (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop  && (r_count != '0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: sequential instruction fetch with a credit-managed
// prefetch FIFO between a 1-cycle-latency instruction memory and decode.
//   clk, rst_n       : clock, synchronous active-low reset
//   imem_en/addr     : memory read strobe and word address
//   imem_rdata       : memory data, valid the cycle after imem_en
//   out_valid/ready  : head-of-FIFO handshake to decode
//   out_pc/out_instr : head {pc, instr}; zero while out_valid is low
//   redirect_valid/pc: flush all speculative fetches and restart at pc
//   fault            : sticky misaligned-redirect flag
// Optional feature macro: FETCH_ALIGN_CHECK_EN enables the misaligned
// redirect fault; without it redirect_pc[1:0] is ignored and fault is 0.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = riscv_pkg::XLEN,
  parameter int unsigned     DEPTH      = 10,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(riscv_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_en,
  output logic [DEPTH-1:0] imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_instr,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             fault
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRW = CW + 1;

  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_inflight_pc;
  logic              r_inflight;
  logic              r_fault;

  logic [CW-1:0]     w_count;
  logic [2*XLEN-1:0] w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_misaligned;
  logic [XLEN-1:0]   w_target;
  logic [CRW-1:0]    w_credit_used;
  logic [CRW-1:0]    w_credit_limit;

  // Low address bits never reach the fetch PC.
  assign w_target = redirect_pc & ~XLEN'(3);

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && out_ready;

  // Credit: stored + outstanding words, less the one leaving this cycle,
  // must stay below FIFO_DEPTH so the response push can never overflow.
  assign w_credit_used  = CRW'(w_count) + CRW'(r_inflight);
  assign w_credit_limit = CRW'(FIFO_DEPTH) + CRW'(w_pop);

  assign w_issue = rst_n && !redirect_valid && !r_fault &&
                   (w_credit_used < w_credit_limit);

  // Response from memory is dropped if a redirect squashes it this cycle.
  assign w_push = r_inflight && !redirect_valid;

  // Fetch PC, outstanding-read tracking and sticky fault.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_fault       <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_fault    <= w_misaligned;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata ({r_inflight_pc, imem_rdata}),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign imem_en   = w_issue;
  assign imem_addr = rst_n ? r_fetch_pc[DEPTH+1:2] : '0;
  assign out_valid = w_valid;
  assign out_pc    = w_valid ? w_head[2*XLEN-1:XLEN] : '0;
  assign out_instr = w_valid ? w_head[XLEN-1:0]      : '0;
  assign fault     = r_fault;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed + randomized stimulus for riscv_fetch_unit
// against a stream-level reference model: each word issued at cycle k is
// visible to decode from cycle k+2, decode sees a gap-free pc sequence from
// the last redirect/reset target, and outstanding words never exceed
// FIFO_DEPTH. Honors FETCH_ALIGN_CHECK_EN like the design.
module tb_riscv_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned AW   = 10;
  localparam int          FD   = 4;
  localparam int unsigned MEMW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          fault;

  logic [31:0] mem [MEMW];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  int          q_stamp[$];   // issue cycle of each word not yet delivered
  logic [31:0] exp_head_pc;  // pc decode should see next
  logic [31:0] exp_fetch_pc; // next address to be requested
  logic        fault_m;

  riscv_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    return mem[pc[AW+1:2]];
  endfunction

  // One clock: drive inputs at negedge, check at negedge+1, advance model.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic exp_valid, pop, exp_en, mis;
    @(negedge clk);
    rst_n = 1'b1; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
    exp_valid = (q_stamp.size() > 0) && (q_stamp[0] + 2 <= cyc);
    pop       = exp_valid && rdy;
    exp_en    = !rv && !fault_m && ((q_stamp.size() - int'(pop)) < FD);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("out_pc", 64'(out_pc), 64'(exp_head_pc));
      chk("out_instr", 64'(out_instr), 64'(mem_at(exp_head_pc)));
    end
    chk("imem_en", 64'(imem_en), 64'(exp_en));
    if (exp_en) chk("imem_addr", 64'(imem_addr), 64'(exp_fetch_pc[AW+1:2]));
    chk("fault", 64'(fault), 64'(fault_m));
    if (rv) begin
      mis = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      mis = (rpc[1:0] != 2'b00);
`endif
      q_stamp.delete();
      fault_m      = mis;
      exp_fetch_pc = rpc & ~32'h3;
      exp_head_pc  = exp_fetch_pc;
    end else begin
      if (pop) begin
        void'(q_stamp.pop_front());
        exp_head_pc = exp_head_pc + 32'd4;
      end
      if (exp_en) begin
        q_stamp.push_back(cyc);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Hold rst_n low for exactly one edge and check reset values after it.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    #1;
    chk("rst_imem_en", 64'(imem_en), 64'(0));
    chk("rst_imem_addr", 64'(imem_addr), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    chk("rst_out_instr", 64'(out_instr), 64'(0));
    chk("rst_fault", 64'(fault), 64'(0));
    q_stamp.delete();
    exp_fetch_pc = RESET_PC;
    exp_head_pc  = RESET_PC;
    fault_m      = 1'b0;
  endtask

  initial begin
    logic        rdy, rv;
    logic [31:0] rpc;
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < int'(MEMW); i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) mem[i] = NOP_INSTR + 32'(i);

    // Reset release, streaming with decode always ready.
    do_reset();
    repeat (20) cycle(1'b1, 1'b0, 32'h0);

    // Long stall, then release.
    repeat (10) cycle(1'b0, 1'b0, 32'h0);
    repeat (12) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with credits exhausted and a read outstanding.
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h40);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);

    // Redirect on a full FIFO, simultaneous with a handshake.
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h80);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Memory address wrap at the top word.
    cycle(1'b1, 1'b1, (32'(MEMW) - 32'd1) * 32'd4);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect, then an aligned one.
    cycle(1'b1, 1'b1, 32'h42);
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h44);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Randomized backpressure and redirects.
    repeat (400) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc = rpc & ~32'h3;
      cycle(rdy, rv, rpc);
    end

    // One-cycle reset mid-stream, then restart from RESET_PC.
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    do_reset();
    repeat (15) cycle(1'b1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
